nios_system_meas_in: RTL and testbench
======================================

// Module: nios_system_meas_in
// PURPOSE
// - Avalon-MM slave input PIO: brings an external WIDTH-bit measurement bus (e.g. ADC position word) into the Nios II.
// - Input-side counterpart of the system's output PIOs (gain/setpoint registers): CPU reads the data, the block never drives it.
// - Synchronises in_port, detects per-bit edges, latches them in an edge-capture register, raises a maskable IRQ.
// - Sits in nios_system next to the output PIOs on the same data-master bus.
// PARAMETERS
// - WIDTH        10  bits of in_port / data register (1..32)
// - EDGE_TYPE    0   capture on 0=rising, 1=falling, 2=any edge
// - SYNC_STAGES  2   flops in the input synchroniser (2..4)
// PORTS
// - clk        in   1      system clock; all logic on posedge
// - reset      in   1      synchronous, active-high reset
// - address    in   2      word offset: 0 DATA, 1 reserved, 2 IRQMASK, 3 EDGECAP
// - chipselect in   1      slave select
// - write_n    in   1      active-low write strobe (qualified by chipselect)
// - writedata  in   32     write data; bits [WIDTH-1:0] used
// - in_port    in   WIDTH  asynchronous external input bus
// - readdata   out  32     registered read data, zero-extended above WIDTH
// - irq        out  1      level interrupt to CPU
// BEHAVIOUR
// - Reset (reset=1 at posedge): sync chain, prev, irq_mask, edge_cap, readdata = 0; arm counter = 0; irq = 0.
// - Sync: in_port -> SYNC_STAGES flops -> s; prev <= s every cycle. Value in DATA lags in_port by SYNC_STAGES cycles.
// - Arm: counter counts 0..SYNC_STAGES+1 after reset, then saturates; edge detection disabled until saturated
//   (no spurious capture from chain filling after reset).
// - Edge: rise = s & ~prev, fall = ~s & prev; edge = rise | fall | both per EDGE_TYPE; gated by armed.
// - EDGECAP: edge_cap <= (edge_cap & ~clr) | edge, clr = writedata[WIDTH-1:0] on write to offset 3 (write-1-to-clear).
//   Simultaneous edge and clear on same bit: edge wins, bit stays 1.
// - IRQMASK: write to offset 2 loads writedata[WIDTH-1:0]; readable.
// - Writes to offset 0 and 1 ignored. Write = chipselect & ~write_n.
// - irq = |(edge_cap & irq_mask), combinational from registers: asserts the cycle after the capturing edge
//   or mask write, deasserts the cycle after the clearing write.
// - Read: readdata <= mux(address) every cycle (no read strobe); latency 1 cycle; offset 0 -> s, 1 -> 0,
//   2 -> irq_mask, 3 -> edge_cap; upper 32-WIDTH bits always 0.
// - Reset mid-operation: all state cleared including pending captures; arm period restarts.
// STRUCTURE
// - Shared package nios_system_pio_pkg: offsets ADDR_DATA=0, ADDR_IRQMASK=2, ADDR_EDGECAP=3; EDGE_RISE/FALL/ANY constants.
// - One sub-module: nios_system_sync_chain (WIDTH, SYNC_STAGES; clk, reset, d, q); reused by other input PIOs.
// - Edge logic, registers, read mux and arm counter inline in the top.
// TESTING
// - Reset with in_port=10'h3FF held -> no edge_cap bits set, irq=0; DATA reads 0x3FF by cycle SYNC_STAGES+2 after release.
// - EDGE_TYPE=0, mask=0x001: in_port 0x000->0x001 -> EDGECAP reads 0x001, irq=1 within SYNC_STAGES+2 cycles.
// - Write 0x001 to offset 3 -> EDGECAP 0x000, irq=0 next cycle; rising edge bit0 same cycle as clear -> bit stays 1.
// - EDGE_TYPE=2: toggle bit9 1->0, mask=0 -> EDGECAP 0x200, irq=0; write mask 0x200 -> irq=1 next cycle.
// - Reads: offset 1 -> 0; writedata 0xFFFF_FFFF to offset 2 -> IRQMASK reads 0x0000_03FF; write to offset 0 no effect.
// - Assert reset with edge_cap=0x155 pending -> edge_cap=0, irq=0, readdata=0 next cycle.

Source files
------------

// File: rtl/nios_system_pio_pkg.sv
// rtl/nios_system_pio_pkg.sv - register offsets and edge-type codes shared by the nios_system PIOs
package nios_system_pio_pkg;

  localparam logic [1:0] ADDR_DATA    = 2'd0;
  localparam logic [1:0] ADDR_RSVD    = 2'd1;
  localparam logic [1:0] ADDR_IRQMASK = 2'd2;
  localparam logic [1:0] ADDR_EDGECAP = 2'd3;

  localparam int EDGE_RISE = 0;
  localparam int EDGE_FALL = 1;
  localparam int EDGE_ANY  = 2;

endpackage

// File: rtl/nios_system_sync_chain.sv
// rtl/nios_system_sync_chain.sv - multi-flop synchroniser for an asynchronous input bus
module nios_system_sync_chain #(
  parameter int WIDTH       = 10,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stage [SYNC_STAGES];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) stage[i] <= '0;
    end else begin
      stage[0] <= d;
      for (int i = 1; i < SYNC_STAGES; i++) stage[i] <= stage[i-1];
    end
  end

  assign q = stage[SYNC_STAGES-1];

endmodule

// File: rtl/nios_system_meas_in.sv
// rtl/nios_system_meas_in.sv - input PIO with edge capture and maskable IRQ for the measurement bus
module nios_system_meas_in
  import nios_system_pio_pkg::*;
#(
  parameter int WIDTH       = 10,
  parameter int EDGE_TYPE   = EDGE_RISE,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  localparam int CNT_W = $clog2(SYNC_STAGES + 2);
  localparam logic [CNT_W-1:0] ARM_MAX = CNT_W'(SYNC_STAGES + 1);

  logic [WIDTH-1:0] s;
  logic [WIDTH-1:0] prev;
  logic [WIDTH-1:0] irq_mask;
  logic [WIDTH-1:0] edge_cap;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;
  logic [WIDTH-1:0] edge_det;
  logic [WIDTH-1:0] clr;
  logic [WIDTH-1:0] rd_mux;
  logic [CNT_W-1:0] arm_cnt;
  logic             armed;
  logic             wr_en;
  logic             unused_wdata;

  nios_system_sync_chain #(
    .WIDTH      (WIDTH),
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk  (clk),
    .reset(reset),
    .d    (in_port),
    .q    (s)
  );

  assign wr_en        = chipselect & ~write_n;
  assign armed        = (arm_cnt == ARM_MAX);
  assign unused_wdata = ^writedata;

  always_comb begin
    rise     = s & ~prev;
    fall     = ~s & prev;
    edge_det = '0;
    if (EDGE_TYPE == EDGE_RISE)      edge_det = rise;
    else if (EDGE_TYPE == EDGE_FALL) edge_det = fall;
    else                             edge_det = rise | fall;
    // Suppress edges while the chain and prev are still filling after reset.
    if (!armed) edge_det = '0;

    clr = '0;
    if (wr_en && address == ADDR_EDGECAP) clr = writedata[WIDTH-1:0];

    rd_mux = '0;
    case (address)
      ADDR_DATA:    rd_mux = s;
      ADDR_IRQMASK: rd_mux = irq_mask;
      ADDR_EDGECAP: rd_mux = edge_cap;
      default:      rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      prev     <= '0;
      irq_mask <= '0;
      edge_cap <= '0;
      arm_cnt  <= '0;
      readdata <= '0;
    end else begin
      prev <= s;
      if (!armed) arm_cnt <= arm_cnt + CNT_W'(1);
      // A new edge overrides a same-cycle clear of that bit.
      edge_cap <= (edge_cap & ~clr) | edge_det;
      if (wr_en && address == ADDR_IRQMASK) irq_mask <= writedata[WIDTH-1:0];
      readdata <= 32'(rd_mux);
    end
  end

  assign irq = |(edge_cap & irq_mask);

endmodule

// File: tb/tb_nios_system_meas_in.sv
// tb/tb_nios_system_meas_in.sv - randomized model-checked bench for nios_system_meas_in
module tb_nios_system_meas_in;

  localparam int W = 10;
  localparam int S = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic [1:0]    address;
  logic          chipselect;
  logic          write_n;
  logic [31:0]   writedata;
  logic [W-1:0]  in_port;
  logic [31:0]   rd_rise, rd_any;
  logic          irq_rise, irq_any;

  always #5 clk = ~clk;

  nios_system_meas_in #(.WIDTH(W), .EDGE_TYPE(0), .SYNC_STAGES(S)) dut_rise (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in_port),
    .readdata(rd_rise), .irq(irq_rise)
  );

  nios_system_meas_in #(.WIDTH(W), .EDGE_TYPE(2), .SYNC_STAGES(S)) dut_any (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in_port),
    .readdata(rd_any), .irq(irq_any)
  );

  int tests = 0;
  int fails = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Reference model: index 0 = rising-edge instance, 1 = any-edge instance
  logic [W-1:0] dline[$];
  logic [W-1:0] m_prev;
  logic [W-1:0] m_mask;
  logic [W-1:0] m_cap [2];
  logic [31:0]  m_rd  [2];
  int           m_cyc;

  task automatic model_reset();
    dline = {};
    for (int i = 0; i < S; i++) dline.push_back('0);
    m_prev = '0;
    m_mask = '0;
    m_cyc  = 0;
    for (int k = 0; k < 2; k++) begin
      m_cap[k] = '0;
      m_rd[k]  = '0;
    end
  endtask

  task automatic model_step();
    logic [W-1:0] s, ev, clr;
    bit wr;
    if (reset) begin
      model_reset();
    end else begin
      s   = dline[0];
      wr  = chipselect && !write_n;
      clr = (wr && address == 2'd3) ? writedata[W-1:0] : '0;
      for (int k = 0; k < 2; k++) begin
        ev = (k == 0) ? (s & ~m_prev) : (s ^ m_prev);
        if (m_cyc < S + 1) ev = '0;
        case (address)
          2'd0:    m_rd[k] = 32'(s);
          2'd2:    m_rd[k] = 32'(m_mask);
          2'd3:    m_rd[k] = 32'(m_cap[k]);
          default: m_rd[k] = 32'd0;
        endcase
        m_cap[k] = (m_cap[k] & ~clr) | ev;
      end
      if (wr && address == 2'd2) m_mask = writedata[W-1:0];
      m_prev = s;
      dline.push_back(in_port);
      void'(dline.pop_front());
      if (m_cyc < S + 1) m_cyc++;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check("rd_rise", rd_rise, m_rd[0]);
    check("rd_any", rd_any, m_rd[1]);
    check("irq_rise", 32'(irq_rise), 32'(|(m_cap[0] & m_mask)));
    check("irq_any", 32'(irq_any), 32'(|(m_cap[1] & m_mask)));
  endtask

  task automatic do_write(input logic [1:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    tick();
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  initial begin
    model_reset();
    reset = 1'b1; in_port = 10'h3FF; chipselect = 1'b0; write_n = 1'b1;
    address = 2'd0; writedata = '0;
    @(negedge clk);
    tick(); tick();
    check("rst_rd", rd_rise, 32'h0);
    check("rst_irq", 32'(irq_rise), 32'h0);
    reset = 1'b0;

    // Chain fills with 0x3FF: DATA follows, no capture
    for (int i = 0; i < S + 1; i++) tick();
    check("data_3ff", rd_rise, 32'h3FF);
    address = 2'd3;
    tick();
    check("no_spur_rise", rd_rise, 32'h0);
    check("no_spur_any", rd_any, 32'h0);

    // Rising edge on bit0 with mask 0x001
    in_port = '0;
    repeat (4) tick();
    do_write(2'd3, 32'h3FF);
    do_write(2'd2, 32'h001);
    address = 2'd3;
    in_port = 10'h001;
    for (int i = 0; i < S + 1; i++) tick();
    check("irq_bit0", 32'(irq_rise), 32'h1);
    tick();
    check("cap_bit0", rd_rise, 32'h001);
    do_write(2'd3, 32'h001);
    check("irq_clr", 32'(irq_rise), 32'h0);

    // Clear coinciding with a capture: edge wins
    in_port = '0;
    repeat (4) tick();
    do_write(2'd3, 32'h3FF);
    in_port = 10'h001;
    for (int i = 0; i < S; i++) tick();
    do_write(2'd3, 32'h001);
    check("edge_wins", 32'(irq_rise), 32'h1);
    tick();
    check("edge_wins_rd", rd_rise, 32'h001);

    // Any-edge: falling bit9, masked then unmasked
    do_write(2'd2, 32'h0);
    in_port = 10'h200;
    repeat (4) tick();
    do_write(2'd3, 32'h3FF);
    in_port = '0;
    for (int i = 0; i < S + 2; i++) tick();
    address = 2'd3;
    tick();
    check("any_cap", rd_any, 32'h200);
    check("any_irq0", 32'(irq_any), 32'h0);
    check("rise_nocap", rd_rise, 32'h0);
    do_write(2'd2, 32'h200);
    check("any_irq1", 32'(irq_any), 32'h1);

    // Register map reads
    address = 2'd1;
    tick();
    check("rsvd_zero", rd_rise, 32'h0);
    do_write(2'd2, 32'hFFFF_FFFF);
    address = 2'd2;
    tick();
    check("mask_zext", rd_rise, 32'h0000_03FF);
    do_write(2'd0, 32'h155);
    address = 2'd0;
    tick();
    check("data_ro", rd_rise, 32'h0);

    // Randomized traffic with occasional reset
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 3) == 0) in_port = W'($urandom);
      address    = 2'($urandom_range(0, 3));
      writedata  = $urandom;
      chipselect = ($urandom_range(0, 3) == 0);
      write_n    = ($urandom_range(0, 1) == 0);
      reset      = ($urandom_range(0, 99) == 0);
      tick();
    end
    reset = 1'b0; chipselect = 1'b0; write_n = 1'b1;

    // Reset with captures pending
    for (int i = 0; i < S + 2; i++) tick();
    do_write(2'd2, 32'h3FF);
    in_port = '0;
    repeat (4) tick();
    do_write(2'd3, 32'h3FF);
    in_port = 10'h155;
    for (int i = 0; i < S + 2; i++) tick();
    address = 2'd3;
    tick();
    check("pend_155", rd_rise, 32'h155);
    check("pend_irq", 32'(irq_rise), 32'h1);
    reset = 1'b1;
    tick();
    check("mid_rst_rd", rd_rise, 32'h0);
    check("mid_rst_irq", 32'(irq_rise), 32'h0);
    check("mid_rst_any", rd_any, 32'h0);
    reset = 1'b0;
    for (int i = 0; i < S + 3; i++) tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
